// File: rtl/mimc_round_sequencer.sv
// MiMC-p/p round sequencer over a prime field.
// Each round computes x <= (x + k + c_i)^7 mod p using an external
// galois_pow_7 unit for the exponentiation. After the last round it
// publishes x + k mod p. Round constants come from a synchronous ROM
// with one cycle of read latency.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for en; pow unit held in reset; rc_addr parked at 0
// ADD_K    | t <= x + k mod p
// ADD_C    | pow_base <= t + c_i mod p (ROM data for rc_addr valid here)
// POW_RST  | one-cycle reset pulse to the pow unit, clears any stale done
// POW_WAIT | pow unit running; on pow_done latch x and advance the round
// FINAL    | x_out <= x + k mod p
// DONE     | result valid; held until en drops
module mimc_round_sequencer #(
  parameter int                N_BITS       = 254,
  parameter int                N_ROUNDS     = 91,
  parameter logic [N_BITS-1:0] PRIME        = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int                RC_ADDR_BITS = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_BITS-1:0]       x_in,
  input  logic [N_BITS-1:0]       k_in,
  output logic [N_BITS-1:0]       x_out,
  output logic                    done,
  output logic [RC_ADDR_BITS-1:0] rc_addr,
  input  logic [N_BITS-1:0]       rc_data,
  output logic                    pow_rst,
  output logic                    pow_en,
  output logic [N_BITS-1:0]       pow_base,
  input  logic [N_BITS-1:0]       pow_result,
  input  logic                    pow_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADD_K    = 3'd1,
    ADD_C    = 3'd2,
    POW_RST  = 3'd3,
    POW_WAIT = 3'd4,
    FINAL    = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [RC_ADDR_BITS-1:0] LAST_ROUND = RC_ADDR_BITS'(N_ROUNDS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [N_BITS-1:0]       x_q;
  logic [N_BITS-1:0]       k_q;
  logic [N_BITS-1:0]       t_q;
  logic [RC_ADDR_BITS-1:0] round_q;
  logic                    last_round;
  logic                    busy;

  // Field addition; both operands are assumed already reduced below PRIME,
  // so a single conditional subtraction is enough.
  function automatic logic [N_BITS-1:0] mod_add(
    input logic [N_BITS-1:0] a,
    input logic [N_BITS-1:0] b
  );
    logic [N_BITS:0] s;
    logic [N_BITS:0] p_ext;
    s     = {1'b0, a} + {1'b0, b};
    p_ext = {1'b0, PRIME};
    return N_BITS'((s >= p_ext) ? (s - p_ext) : s);
  endfunction

  assign last_round = (round_q == LAST_ROUND);
  // Every state except the two resting ones requires en to stay high.
  assign busy       = (state != IDLE) && (state != DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; dropping en mid-hash aborts straight back to IDLE
  always_comb begin
    state_next = state;
    if (busy && !en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (en) state_next = ADD_K;
        ADD_K:    state_next = ADD_C;
        ADD_C:    state_next = POW_RST;
        POW_RST:  state_next = POW_WAIT;
        POW_WAIT: begin
          if (pow_done) begin
            state_next = last_round ? FINAL : ADD_K;
          end
        end
        FINAL:    state_next = DONE;
        DONE:     if (!en) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Control outputs decoded from the current state
  always_comb begin
    pow_rst = 1'b1;
    pow_en  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:     pow_rst = 1'b1;
      ADD_K:    pow_rst = 1'b0;
      ADD_C:    pow_rst = 1'b0;
      POW_RST:  pow_rst = 1'b1;
      POW_WAIT: begin
        pow_rst = 1'b0;
        pow_en  = 1'b1;
      end
      FINAL:    pow_rst = 1'b1;
      DONE: begin
        pow_rst = 1'b1;
        done    = 1'b1;
      end
      default:  pow_rst = 1'b1;
    endcase
  end

  // Datapath: operand capture, field additions, round/ROM address tracking.
  // The constant is consumed in ADD_C because the ROM needs one cycle after
  // rc_addr settles (rc_addr changes on entry to ADD_K).
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      k_q      <= '0;
      t_q      <= '0;
      round_q  <= '0;
      rc_addr  <= '0;
      pow_base <= '0;
      x_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          rc_addr <= '0;
          round_q <= '0;
          if (en) begin
            x_q <= x_in;
            k_q <= k_in;
          end
        end
        ADD_K: begin
          if (en) t_q <= mod_add(x_q, k_q);
        end
        ADD_C: begin
          if (en) pow_base <= mod_add(t_q, rc_data);
        end
        POW_WAIT: begin
          if (en && pow_done) begin
            x_q <= pow_result;
            if (!last_round) begin
              round_q <= round_q + 1'b1;
              rc_addr <= round_q + 1'b1;
            end
          end
        end
        FINAL: begin
          if (en) x_out <= mod_add(x_q, k_q);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
